// File: rtl/regdest_pkg.sv
// regdest_pkg
//   Shared definitions for the destination-register tracker:
//   destination-select encodings and the default stack-pointer /
//   link-register numbers of the MIPS register file.
package regdest_pkg;

    // Destination select encodings driven by the control unit
    localparam logic [1:0] SEL_RT = 2'd0;
    localparam logic [1:0] SEL_RD = 2'd1;
    localparam logic [1:0] SEL_SP = 2'd2;
    localparam logic [1:0] SEL_RA = 2'd3;

    // Default architectural register numbers
    localparam int SP_REG_DEFAULT = 29;
    localparam int RA_REG_DEFAULT = 31;

endpackage : regdest_pkg

// File: rtl/regdest_queue.sv
// regdest_queue
//   In-order circular buffer of pending destination registers.
//   Entries carry valid bits so that the two source lookups can be
//   compared against every outstanding destination in parallel.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   push, push_data - append a destination at the tail
//   pop             - retire the head entry (caller guarantees non-empty)
//   src_a, src_b    - source registers to look up
//   head            - oldest pending destination
//   count           - occupancy, 0..PEND_DEPTH
//   match_a/match_b - per-entry hit vectors for the two lookups
module regdest_queue #(
    parameter int REG_ADDR_W = 5,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = $clog2(PEND_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_data,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    output logic [REG_ADDR_W-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic [PEND_DEPTH-1:0] match_a,
    output logic [PEND_DEPTH-1:0] match_b
);

    localparam int PTR_W = $clog2(PEND_DEPTH);

    logic [REG_ADDR_W-1:0] entries [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Pointers wrap naturally because the depth is a power of two.
    // The pop is applied before the push so that when a full queue
    // retires and issues in the same cycle (both pointers on the same
    // slot) the new entry's valid bit survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                entries[i] <= '0;
            end
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                entries[wr_ptr] <= push_data;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            match_a[i] = valid[i] && (entries[i] == src_a);
            match_b[i] = valid[i] && (entries[i] == src_b);
        end
    end

    assign head = entries[rd_ptr];

endmodule : regdest_queue

// File: rtl/regdest_tracker.sv
// regdest_tracker
//   Destination-register unit for the multicycle MIPS datapath. Picks
//   the write-back destination (rt, rd, SP or RA), registers it, keeps
//   every issued destination pending until write-back retires it, and
//   flags RAW hazards for two source lookups.
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-low reset
//   instr_rt, instr_rd   - instruction register fields
//   sel                  - destination select (rt/rd/SP/RA)
//   issue_valid/ready    - issue handshake
//   dest, dest_valid     - registered destination and one-cycle strobe
//   wb_valid, wb_addr    - write-back retire of the oldest destination
//   src_a, src_b         - source lookups
//   hazard_a, hazard_b   - lookup matches a pending destination
//   pend_count           - queue occupancy
//   err                  - sticky protocol error
module regdest_tracker
    import regdest_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SP_REG     = SP_REG_DEFAULT,
    parameter int RA_REG     = RA_REG_DEFAULT,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = $clog2(PEND_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] instr_rt,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [1:0]            sel,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  dest_valid,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [CNT_W-1:0]      pend_count,
    output logic                  err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PEND_DEPTH);

    logic [REG_ADDR_W-1:0] sel_dest;
    logic [REG_ADDR_W-1:0] head;
    logic [PEND_DEPTH-1:0] match_a;
    logic [PEND_DEPTH-1:0] match_b;
    logic                  issue_fire;
    logic                  pop;
    logic                  not_empty;

    always_comb begin
        sel_dest = instr_rt;
        case (sel)
            SEL_RT:  sel_dest = instr_rt;
            SEL_RD:  sel_dest = instr_rd;
            SEL_SP:  sel_dest = REG_ADDR_W'(SP_REG);
            SEL_RA:  sel_dest = REG_ADDR_W'(RA_REG);
            default: sel_dest = instr_rt;
        endcase
    end

    // A full queue may still accept an issue when a retire frees the
    // head slot in the same cycle.
    assign not_empty   = (pend_count != '0);
    assign issue_ready = (pend_count < DEPTH_C) || (wb_valid && not_empty);
    assign issue_fire  = issue_valid && issue_ready;
    assign pop         = wb_valid && not_empty;

    regdest_queue #(
        .REG_ADDR_W (REG_ADDR_W),
        .PEND_DEPTH (PEND_DEPTH),
        .CNT_W      (CNT_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_fire),
        .push_data (sel_dest),
        .pop       (pop),
        .src_a     (src_a),
        .src_b     (src_b),
        .head      (head),
        .count     (pend_count),
        .match_a   (match_a),
        .match_b   (match_b)
    );

    // Register $zero is never a real dependency, so it is masked here
    // even though it still occupies a queue slot for retire ordering.
    assign hazard_a = (src_a != '0) && (|match_a);
    assign hazard_b = (src_b != '0) && (|match_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest       <= '0;
            dest_valid <= 1'b0;
        end else begin
            dest_valid <= issue_fire;
            if (issue_fire) begin
                dest <= sel_dest;
            end
        end
    end

    // Error on retiring from an empty queue or out of order; sticky
    // until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (wb_valid && (!not_empty || (wb_addr != head))) begin
            err <= 1'b1;
        end
    end

endmodule : regdest_tracker

// File: tb/tb_regdest_tracker.sv
// tb_regdest_tracker
//   Directed-vector bench for regdest_tracker with default parameters
//   (5-bit addresses, SP=29, RA=31, depth 4).
module tb_regdest_tracker;
    import regdest_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] instr_rt;
    logic [4:0] instr_rd;
    logic [1:0] sel;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] dest;
    logic       dest_valid;
    logic       wb_valid;
    logic [4:0] wb_addr;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       hazard_a;
    logic       hazard_b;
    logic [2:0] pend_count;
    logic       err;

    int assertCount = 0;
    int failCount   = 0;

    regdest_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .instr_rt    (instr_rt),
        .instr_rd    (instr_rd),
        .sel         (sel),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .dest        (dest),
        .dest_valid  (dest_valid),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .src_a       (src_a),
        .src_b       (src_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .pend_count  (pend_count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of issue/retire, then drop the strobes 1ns after the edge
    task automatic applyStimulus(input logic iv, input logic [1:0] s,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic wv, input logic [4:0] wa);
        issue_valid = iv;
        sel         = s;
        instr_rt    = rt;
        instr_rd    = rd;
        wb_valid    = wv;
        wb_addr     = wa;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        #1;
    endtask

    task automatic lookup(input logic [4:0] a, input logic [4:0] b);
        src_a = a;
        src_b = b;
        #1;
    endtask

    initial begin
        reset = 1'b0; instr_rt = '0; instr_rd = '0; sel = SEL_RT;
        issue_valid = 1'b0; wb_valid = 1'b0; wb_addr = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dest", 32'(dest), 0);
        checkOutput("rst_dest_valid", 32'(dest_valid), 0);
        checkOutput("rst_count", 32'(pend_count), 0);
        checkOutput("rst_err", 32'(err), 0);
        reset = 1'b1;
        #1;
        checkOutput("rst_issue_ready", 32'(issue_ready), 1);

        // SP select after reset
        applyStimulus(1'b1, SEL_SP, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("sp_dest", 32'(dest), 29);
        checkOutput("sp_dest_valid", 32'(dest_valid), 1);
        checkOutput("sp_count", 32'(pend_count), 1);
        lookup(5'd29, 5'd0);
        checkOutput("sp_hazard_a", 32'(hazard_a), 1);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd29);
        checkOutput("sp_dest_valid_pulse", 32'(dest_valid), 0);
        checkOutput("sp_hold_dest", 32'(dest), 29);
        checkOutput("sp_retired_count", 32'(pend_count), 0);
        checkOutput("sp_retired_hazard", 32'(hazard_a), 0);

        // Selection of rt, rd, RA
        applyStimulus(1'b1, SEL_RT, 5'd8, 5'd1, 1'b0, 5'd0);
        checkOutput("sel_rt_dest", 32'(dest), 8);
        applyStimulus(1'b1, SEL_RD, 5'd2, 5'd9, 1'b0, 5'd0);
        checkOutput("sel_rd_dest", 32'(dest), 9);
        applyStimulus(1'b1, SEL_RA, 5'd3, 5'd4, 1'b0, 5'd0);
        checkOutput("sel_ra_dest", 32'(dest), 31);
        checkOutput("sel_count", 32'(pend_count), 3);
        lookup(5'd8, 5'd9);
        checkOutput("sel_haz_8", 32'(hazard_a), 1);
        checkOutput("sel_haz_9", 32'(hazard_b), 1);
        lookup(5'd31, 5'd10);
        checkOutput("sel_haz_31", 32'(hazard_a), 1);
        checkOutput("sel_haz_10", 32'(hazard_b), 0);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd8);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd9);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd31);
        checkOutput("sel_drained_count", 32'(pend_count), 0);
        checkOutput("sel_drained_err", 32'(err), 0);

        // Full queue, then issue together with a matching retire
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, SEL_RT, 5'(i), 5'd0, 1'b0, 5'd0);
        end
        checkOutput("full_count", 32'(pend_count), 4);
        checkOutput("full_issue_ready", 32'(issue_ready), 0);
        issue_valid = 1'b1; sel = SEL_RT; instr_rt = 5'd5;
        wb_valid = 1'b1; wb_addr = 5'd1;
        src_a = 5'd1; src_b = 5'd5;
        #1;
        checkOutput("full_retire_ready", 32'(issue_ready), 1);
        checkOutput("full_retiring_visible", 32'(hazard_a), 1);
        checkOutput("full_issue_invisible", 32'(hazard_b), 0);
        @(posedge clk);
        #1;
        issue_valid = 1'b0; wb_valid = 1'b0;
        #1;
        checkOutput("full_swap_count", 32'(pend_count), 4);
        checkOutput("full_swap_dest", 32'(dest), 5);
        checkOutput("full_swap_err", 32'(err), 0);
        checkOutput("full_swap_haz_1", 32'(hazard_a), 0);
        checkOutput("full_swap_haz_5", 32'(hazard_b), 1);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'(i));
        end
        checkOutput("full_drained_count", 32'(pend_count), 0);
        checkOutput("full_drained_err", 32'(err), 0);

        // Retire order and mismatch error
        applyStimulus(1'b1, SEL_RT, 5'd5, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, SEL_RT, 5'd6, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd5);
        lookup(5'd5, 5'd6);
        checkOutput("order_haz_5", 32'(hazard_a), 0);
        checkOutput("order_haz_6", 32'(hazard_b), 1);
        checkOutput("order_err", 32'(err), 0);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd7);
        checkOutput("mismatch_err", 32'(err), 1);
        checkOutput("mismatch_count", 32'(pend_count), 0);

        // Destination zero and duplicates
        applyStimulus(1'b1, SEL_RT, 5'd0, 5'd0, 1'b0, 5'd0);
        lookup(5'd0, 5'd0);
        checkOutput("zero_count", 32'(pend_count), 1);
        checkOutput("zero_no_hazard", 32'(hazard_a), 0);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd0);
        applyStimulus(1'b1, SEL_RD, 5'd0, 5'd12, 1'b0, 5'd0);
        applyStimulus(1'b1, SEL_RD, 5'd0, 5'd12, 1'b0, 5'd0);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd12);
        lookup(5'd12, 5'd12);
        checkOutput("dup_haz_held", 32'(hazard_a), 1);
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd12);
        checkOutput("dup_haz_cleared", 32'(hazard_b), 0);
        checkOutput("err_sticky", 32'(err), 1);

        // Reset clears err, then empty-queue retires
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset_clears_err", 32'(err), 0);
        reset = 1'b1;
        applyStimulus(1'b0, SEL_RT, 5'd0, 5'd0, 1'b1, 5'd3);
        checkOutput("empty_retire_err", 32'(err), 1);
        checkOutput("empty_retire_count", 32'(pend_count), 0);
        applyStimulus(1'b1, SEL_RT, 5'd14, 5'd0, 1'b1, 5'd14);
        checkOutput("empty_issue_retire_count", 32'(pend_count), 1);
        lookup(5'd14, 5'd0);
        checkOutput("empty_issue_retire_haz", 32'(hazard_a), 1);

        // Asynchronous reset with entries pending
        applyStimulus(1'b1, SEL_RT, 5'd1, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, SEL_RT, 5'd2, 5'd0, 1'b0, 5'd0);
        checkOutput("pre_reset_count", 32'(pend_count), 3);
        lookup(5'd1, 5'd14);
        checkOutput("pre_reset_haz", 32'(hazard_a), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_count", 32'(pend_count), 0);
        checkOutput("async_err", 32'(err), 0);
        checkOutput("async_haz_a", 32'(hazard_a), 0);
        checkOutput("async_haz_b", 32'(hazard_b), 0);
        checkOutput("async_dest", 32'(dest), 0);
        checkOutput("async_dest_valid", 32'(dest_valid), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", 32'(issue_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_regdest_tracker

// File: doc/regdest_tracker.md
Name: regdest_tracker

Overview:
- Parametrised next-generation destination-register unit for the multicycle MIPS datapath.
- Selects the write-back destination from rt, rd, the stack-pointer constant or the link-register constant, and registers it.
- Records every issued destination in an in-order pending queue until write-back retires it.
- Reports RAW hazards for two source lookups so control can stall.
- Sits between the instruction register / control unit and the register-file write port.

Parameters:
- REG_ADDR_W, 5, register address width (register count = 2**REG_ADDR_W).
- SP_REG, 29, destination driven when sel=2.
- RA_REG, 31, destination driven when sel=3.
- PEND_DEPTH, 4, maximum outstanding destinations; power of two, at least 2.
- CNT_W, $clog2(PEND_DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_rt  in  REG_ADDR_W  instruction field [20:16].
- instr_rd  in  REG_ADDR_W  instruction field [15:11].
- sel  in  2  0=rt, 1=rd, 2=SP_REG, 3=RA_REG.
- issue_valid  in  1  control requests a destination issue.
- issue_ready  out  1  queue can accept an issue this cycle.
- dest  out  REG_ADDR_W  registered destination of the last accepted issue.
- dest_valid  out  1  one-cycle pulse, the cycle after an accepted issue.
- wb_valid  in  1  write-back retires the oldest pending destination.
- wb_addr  in  REG_ADDR_W  address being written back.
- src_a  in  REG_ADDR_W  source lookup A (rs).
- src_b  in  REG_ADDR_W  source lookup B (rt).
- hazard_a  out  1  src_a matches a pending destination.
- hazard_b  out  1  src_b matches a pending destination.
- pend_count  out  CNT_W  current queue occupancy.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset low, asynchronous):
  - dest=0, dest_valid=0, pend_count=0, err=0.
  - Read/write pointers = 0; all entry-valid bits cleared.
  - hazard_a = hazard_b = 0; issue_ready=1 once reset is released.
- Selection (combinational):
  - sel_dest = instr_rt / instr_rd / SP_REG / RA_REG for sel = 0/1/2/3.
  - Constants are truncated to REG_ADDR_W.
- Issue accept: issue_fire = issue_valid & issue_ready.
- Latency 1: on issue_fire, dest <= sel_dest and dest_valid <= 1 next cycle. Otherwise dest_valid <= 0 and dest holds its value.
- issue_fire pushes sel_dest at the write pointer; the pointer wraps modulo PEND_DEPTH.
- Destination 0 is still queued to keep retire order, but never raises a hazard.
- Retire (wb_valid high):
  - Non-empty queue: pop the head.
  - If wb_addr != head entry, set err; the pop still occurs.
  - Empty queue: no pop, err <= 1, count stays 0.
- issue_ready = (pend_count < PEND_DEPTH) | (wb_valid & pend_count != 0). A full queue accepts an issue in the same cycle as a retire.
- Simultaneous issue and retire: push and pop both occur; pend_count is unchanged.
  - Non-empty queue: the popped entry is the old head.
  - Empty queue: the retire is an error and the push still occurs (count becomes 1).
- Hazards (combinational):
  - hazard_x = (src_x != 0) & OR over valid entries of (entry == src_x).
  - Evaluated against registered queue state. A same-cycle issue is not visible; a same-cycle retire still shows its entry.
  - Duplicate pending destinations are allowed. The hazard clears only when the last matching entry retires.
- pend_count saturates structurally: it never exceeds PEND_DEPTH and never underflows.
- err is cleared only by reset.
- Reset mid-operation: all pending entries are discarded immediately and outputs return to reset values.

Decomposition:
- Shared package (regdest_pkg):
  - Sel encodings: SEL_RT=2'd0, SEL_RD=2'd1, SEL_SP=2'd2, SEL_RA=2'd3.
  - Default register constants: SP_REG=29, RA_REG=31.
- One sub-module, regdest_queue: the parametrised circular buffer with valid bits, pointers, count, and the per-entry compare vectors for the two lookups.
- The top level contains the selection mux, the output register and err.

Test Plan:
- Reset value check: after reset, with sel=2 and issue_valid=1 for one cycle, the next cycle shows dest=29, dest_valid=1, pend_count=1. Then src_a=29 gives hazard_a=1.
- Selection: issue sel=0 with rt=8, then sel=1 with rd=9, then sel=3. Required: dest sequence 8, 9, 31, pend_count=3, hazards on 8, 9 and 31, and no hazard on 10.
- Full condition: 4 issues with no retire give pend_count=4 and issue_ready=0. A fifth issue together with wb_valid (matching head) is accepted and pend_count stays 4.
- Retire order: issue 5, 6, retire wb_addr=5 gives hazard on 5 cleared, hazard on 6 held, err=0. Retire wb_addr=7 gives err=1, pend_count=0.
- Zero and duplicates: issue dest 0 gives no hazard for src 0. Issue dest 12 twice, retire once gives hazard on 12 still 1; retire again gives 0.
- Empty retire and async reset: wb_valid on an empty queue gives err=1, pend_count=0. Reset asserted low mid-cycle with 3 pending gives pend_count=0, err=0, hazards=0 immediately.
